leading_one_decoder: RTL
========================

// Module: leading_one_decoder
// PURPOSE
// - Inverse of the leading_one priority encoder: takes a 4-bit leading-one position code and rebuilds an 8-bit word.
// - Output is either the one-hot word (only the leading bit set) or the thermometer word (leading bit and all lower bits set).
// - Streaming block with valid/ready handshake on both sides and a 2-entry output buffer.
// - Sits downstream of leading_one in normalise/denormalise datapaths.
// PARAMETERS
// - W      8   width of the reconstructed word; position codes are $clog2(W)+1 = 4 bits
// - NONE   15  position code meaning "no ones"; decodes to the all-zero word and is legal
// PORTS
// - clk        in   1   single clock; every flop is on the rising edge
// - rst_n      in   1   asynchronous, active-low reset
// - in_valid   in   1   a position code is offered
// - in_ready   out  1   block accepts the code this cycle
// - in_pos     in   4   leading-one position: 0..W-1, or NONE
// - in_thermo  in   1   1 = thermometer output, 0 = one-hot; sampled with in_pos
// - out_valid  out  1   out_word is valid
// - out_ready  in   1   downstream accepts out_word this cycle
// - out_word   out  W   decoded word
// - out_err    out  1   the word on out_word came from an illegal code
// - err_sticky out  1   set by any accepted illegal code; cleared only by reset
// - dec_count  out  16  count of words delivered (out_valid & out_ready); wraps 0xFFFF -> 0
// BEHAVIOUR
// - Reset (async assert, sync release): buffer empty, out_valid=0, out_word=0, out_err=0, err_sticky=0, dec_count=0, in_ready=1.
// - Transfer rule: an input is accepted iff in_valid & in_ready; an output is delivered iff out_valid & out_ready.
// - Latency: 1 cycle. A code accepted at edge N shows on out_word after edge N when the buffer was empty.
// - Decode, for p = in_pos:
//   - p < W, one-hot: word = 1 << p.
//   - p < W, thermometer: word = (1 << (p+1)) - 1. p=W-1 gives all ones; build this without overflow, using a W+1-bit intermediate.
//   - p == NONE: word = 0, out_err = 0.
//   - W <= p < NONE: word = 0, out_err = 1, err_sticky is set.
// - Buffer: 2-entry FIFO of {word, err}, with head and tail pointers and an occupancy count of 0..2.
//   - in_ready = (count < 2). It is driven from registered state only, with no combinational path from out_ready.
//   - out_valid = (count != 0). out_word and out_err always show the head entry.
//   - Accept and deliver in the same cycle: the count stays the same and the pointers advance. This is legal even when full (count==2 gives in_ready=0, so there is no accept).
//   - Full: in_ready=0 and in_pos is ignored. Empty: out_valid=0 and out_word holds its last value. Do not drive it to X.
// - Outputs are stable while out_valid & !out_ready: out_word and out_err must not change.
// - dec_count increments by 1 on each delivery, independent of err.
// - Reset mid-stream drops all buffered entries; nothing is delivered after rst_n rises until a new accept.
// STRUCTURE
// - Shared package ld_pkg holds: LD_W=8, LD_POS_W=4, LD_POS_NONE=4'hF, and typedef ld_entry_t = struct {logic [LD_W-1:0] word; logic err;}.
// - One sub-module: ld_pos_decode, a purely combinational (pos, thermo) -> (word, err). It is reused by the encoder self-check.
// - The top level holds the FIFO registers, the pointers, the count, err_sticky and dec_count.
// TESTING
// - Reset with out_ready=1. Send pos=3 one-hot, then pos=3 thermo -> out_word 8'b0000_1000, then 8'b0000_1111, each 1 cycle after accept.
// - Boundaries: pos=7 thermo -> 8'hFF. pos=0 one-hot -> 8'h01. pos=NONE -> 8'h00 with out_err=0.
// - Illegal: pos=9 -> out_word 8'h00 and out_err=1. err_sticky=1 and stays 1 across later legal codes until rst_n=0.
// - Backpressure: out_ready=0 and send 3 codes -> 2 accepted, then in_ready=0 and out_word is held. Raise out_ready -> both delivered in order, and dec_count=2.
// - Streaming: in_valid=out_ready=1 for 20 cycles with random pos -> 1 word per cycle and no bubbles. Every word fed back through leading_one returns its pos.
// - Reset mid-stream with the buffer full -> out_valid=0 and dec_count=0 immediately, with in_ready=1 while rst_n is low.

Source files
------------

// File: rtl/leading_one_decoder_pkg.sv
// ld_pkg: shared widths, the "no ones" code and the FIFO entry type for the leading-one decoder.
package ld_pkg;
    localparam int LD_W = 8;
    localparam int LD_POS_W = 4;
    localparam logic [LD_POS_W-1:0] LD_POS_NONE = 4'hF;
    typedef struct packed {
        logic [LD_W-1:0] word;
        logic            err;
    } ld_entry_t;
endpackage

// File: rtl/leading_one_decoder_if.sv
// leading_one_decoder_if: input/output valid-ready streams plus status of the leading-one decoder.
interface leading_one_decoder_if;
    import ld_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [LD_POS_W-1:0] in_pos;
    logic                in_thermo;
    logic                out_valid;
    logic                out_ready;
    logic [LD_W-1:0]     out_word;
    logic                out_err;
    logic                err_sticky;
    logic [15:0]         dec_count;
    modport master (
        output in_valid, in_pos, in_thermo, out_ready,
        input  in_ready, out_valid, out_word, out_err, err_sticky, dec_count
    );
    modport slave (
        input  in_valid, in_pos, in_thermo, out_ready,
        output in_ready, out_valid, out_word, out_err, err_sticky, dec_count
    );
endinterface

// File: rtl/leading_one_decoder_pos_decode.sv
// ld_pos_decode: combinational position code -> one-hot or thermometer word, flagging illegal codes.
module ld_pos_decode
    import ld_pkg::*;
(
    input  logic [LD_POS_W-1:0] pos,
    input  logic                thermo,
    output logic [LD_W-1:0]     word,
    output logic                err
);
    localparam logic [LD_W:0] ONE = (LD_W+1)'(1);
    logic            legal;
    logic [LD_W-1:0] hot;
    logic [LD_W-1:0] fill;
    always_comb begin
        legal = pos < LD_POS_W'(LD_W);
        hot   = LD_W'(ONE << pos);
        // one bit of headroom so the top position yields all ones instead of wrapping
        fill  = LD_W'((ONE << ({1'b0, pos} + 5'd1)) - ONE);
        word  = !legal ? '0 : thermo ? fill : hot;
        err   = !legal && pos != LD_POS_NONE;
    end
endmodule

// File: rtl/leading_one_decoder.sv
// leading_one_decoder: decodes position codes into words through a 2-entry output FIFO.
module leading_one_decoder
    import ld_pkg::*;
(
    input logic                  clk,
    input logic                  rst_n,
    leading_one_decoder_if.slave bus
);
    ld_entry_t       mem_q [2];
    ld_entry_t       mem_d [2];
    ld_entry_t       head_q, head_d;
    logic            hp_q, hp_d, tp_q, tp_d;
    logic [1:0]      count_q, count_d;
    logic            sticky_q, sticky_d;
    logic [15:0]     dec_count_q, dec_count_d;
    logic            accept, deliver;
    logic [LD_W-1:0] dec_word;
    logic            dec_err;
    ld_pos_decode u_dec (
        .pos    (bus.in_pos),
        .thermo (bus.in_thermo),
        .word   (dec_word),
        .err    (dec_err)
    );
    always_comb begin
        accept      = bus.in_valid && count_q != 2'd2;
        deliver     = count_q != 2'd0 && bus.out_ready;
        mem_d       = mem_q;
        if (accept) mem_d[tp_q] = {dec_word, dec_err};
        hp_d        = hp_q ^ deliver;
        tp_d        = tp_q ^ accept;
        count_d     = count_q + {1'b0, accept} - {1'b0, deliver};
        sticky_d    = sticky_q | (accept & dec_err);
        dec_count_d = dec_count_q + {15'd0, deliver};
        // registered head copy keeps the last word visible once the FIFO drains
        head_d      = count_d != 2'd0 ? mem_d[hp_d] : head_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            head_q      <= '0;
            hp_q        <= 1'b0;
            tp_q        <= 1'b0;
            count_q     <= 2'd0;
            sticky_q    <= 1'b0;
            dec_count_q <= 16'd0;
        end else begin
            mem_q       <= mem_d;
            head_q      <= head_d;
            hp_q        <= hp_d;
            tp_q        <= tp_d;
            count_q     <= count_d;
            sticky_q    <= sticky_d;
            dec_count_q <= dec_count_d;
        end
    end
    assign bus.in_ready   = count_q != 2'd2;
    assign bus.out_valid  = count_q != 2'd0;
    assign bus.out_word   = head_q.word;
    assign bus.out_err    = head_q.err;
    assign bus.err_sticky = sticky_q;
    assign bus.dec_count  = dec_count_q;
endmodule
